// File: rtl/jstk_pkg.sv
// Shared definitions for the joystick SPI frame controller: FSM encoding,
// frame geometry and default timing (12 MHz CLK, 100 kHz SCLK).
package jstk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_XFER   = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } jstk_state_t;

   localparam int FRAME_BYTES  = 5;
   localparam int BYTE_CNT_W   = $clog2(FRAME_BYTES);
   localparam int TMR_W        = 16;

   localparam int DEF_HALF_PER = 60;
   localparam int DEF_SS_SETUP = 300;
   localparam int DEF_BYTE_GAP = 120;

   function automatic logic is_last_byte(input logic [BYTE_CNT_W-1:0] cnt);
      return cnt == BYTE_CNT_W'(FRAME_BYTES - 1);
   endfunction

endpackage

// File: rtl/jstk_spi_byte.sv
// One SPI mode-0 byte: 8 bits, each HALF_PER cycles low then HALF_PER high,
// MSB first. o_done marks the final cycle of the byte.
module jstk_spi_byte
   import jstk_pkg::*;
#(
   parameter int HALF_PER = DEF_HALF_PER
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_start,
   input  logic [7:0] i_tx_byte,
   input  logic       i_miso,
   output logic [7:0] o_rx_byte,
   output logic       o_done,
   output logic       o_sclk,
   output logic       o_mosi
);

   localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

   logic          r_active;
   logic          r_phase;
   logic [HW-1:0] r_half;
   logic [2:0]    r_bit;
   logic [7:0]    r_tx;
   logic [7:0]    r_rx;
   logic          w_half_tc;

   assign w_half_tc = (r_half == '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_active <= 1'b0;
         r_phase  <= 1'b0;
         r_half   <= '0;
         r_bit    <= '0;
         r_tx     <= '0;
         r_rx     <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_phase  <= 1'b0;
         r_half   <= HW'(HALF_PER - 1);
         r_bit    <= '0;
         r_tx     <= i_tx_byte;
      end else if (r_active) begin
         if (w_half_tc) begin
            r_half  <= HW'(HALF_PER - 1);
            r_phase <= ~r_phase;
            if (!r_phase) begin
               r_rx <= {r_rx[6:0], i_miso};
            end else begin
               // tx drains to zero after 8 shifts, which keeps MOSI low between bytes
               r_tx <= {r_tx[6:0], 1'b0};
               if (r_bit == 3'd7)
                  r_active <= 1'b0;
               else
                  r_bit <= r_bit + 1'b1;
            end
         end else begin
            r_half <= r_half - 1'b1;
         end
      end
   end

   assign o_done    = r_active & r_phase & w_half_tc & (r_bit == 3'd7);
   assign o_sclk    = r_phase;
   assign o_mosi    = r_tx[7];
   assign o_rx_byte = r_rx;

endmodule

// File: rtl/jstk_spi_ctrl.sv
// Joystick SPI frame sequencer: one 5-byte exchange per sndRec rising edge,
// owning SS, setup/inter-byte gaps and the received-frame register.
//
//   state  | meaning
//   IDLE   | SS high, waiting for a fresh sndRec rising edge
//   SETUP  | SS low, SCLK low for SS_SETUP cycles
//   XFER   | one byte shifting in jstk_spi_byte
//   GAP    | SCLK low for BYTE_GAP cycles between bytes
//   FINISH | SS high, DOUT loaded, DONE pulse
module jstk_spi_ctrl
   import jstk_pkg::*;
#(
   parameter int HALF_PER = DEF_HALF_PER,
   parameter int SS_SETUP = DEF_SS_SETUP,
   parameter int BYTE_GAP = DEF_BYTE_GAP
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        sndRec,
   input  logic [39:0] DIN,
   input  logic        MISO,
   output logic        SS,
   output logic        SCLK,
   output logic        MOSI,
   output logic [39:0] DOUT,
   output logic        BUSY,
   output logic        DONE
);

   jstk_state_t           r_state;
   jstk_state_t           w_next;
   logic                  r_snd_q;
   logic                  r_armed;
   logic [TMR_W-1:0]      r_tmr;
   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic [39:0]           r_tx_frame;
   logic [31:0]           r_rx_frame;
   logic [39:0]           r_dout;

   logic                  w_edge;
   logic                  w_go;
   logic                  w_tc;
   logic                  w_start;
   logic                  w_byte_done;
   logic [7:0]            w_rx_byte;

   // r_armed blocks a level that is already high when reset releases
   assign w_edge = sndRec & ~r_snd_q & r_armed;
   assign w_go   = (r_state == ST_IDLE) & w_edge;
   assign w_tc   = (r_tmr == '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      SS      = 1'b1;
      BUSY    = 1'b1;
      DONE    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            BUSY = 1'b0;
            if (w_edge) w_next = ST_SETUP;
         end
         ST_SETUP: begin
            SS = 1'b0;
            if (w_tc) begin
               w_next  = ST_XFER;
               w_start = 1'b1;
            end
         end
         ST_XFER: begin
            SS = 1'b0;
            if (w_byte_done)
               w_next = is_last_byte(r_byte_cnt) ? ST_FINISH : ST_GAP;
         end
         ST_GAP: begin
            SS = 1'b0;
            if (w_tc) begin
               w_next  = ST_XFER;
               w_start = 1'b1;
            end
         end
         ST_FINISH: begin
            DONE   = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            BUSY   = 1'b0;
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_snd_q    <= 1'b0;
         r_armed    <= 1'b0;
         r_tmr      <= '0;
         r_byte_cnt <= '0;
         r_tx_frame <= '0;
         r_rx_frame <= '0;
         r_dout     <= '0;
      end else begin
         r_snd_q <= sndRec;
         r_armed <= r_armed | ~sndRec;

         if (w_go)
            r_tmr <= TMR_W'(SS_SETUP - 1);
         else if ((r_state == ST_XFER) && w_byte_done)
            r_tmr <= TMR_W'(BYTE_GAP - 1);
         else if (!w_tc)
            r_tmr <= r_tmr - 1'b1;

         if (w_go)
            r_tx_frame <= DIN;
         else if (w_start)
            r_tx_frame <= {r_tx_frame[31:0], 8'h00};

         if (w_go) begin
            r_byte_cnt <= '0;
         end else if ((r_state == ST_XFER) && w_byte_done) begin
            r_rx_frame <= {r_rx_frame[23:0], w_rx_byte};
            if (is_last_byte(r_byte_cnt))
               r_dout <= {r_rx_frame, w_rx_byte};
            else
               r_byte_cnt <= r_byte_cnt + 1'b1;
         end
      end
   end

   assign DOUT = r_dout;

   jstk_spi_byte #(
      .HALF_PER (HALF_PER)
   ) u_byte (
      .CLK       (CLK),
      .RST       (RST),
      .i_start   (w_start),
      .i_tx_byte (r_tx_frame[39:32]),
      .i_miso    (MISO),
      .o_rx_byte (w_rx_byte),
      .o_done    (w_byte_done),
      .o_sclk    (SCLK),
      .o_mosi    (MOSI)
   );

endmodule
